case_stream_ctrl: RTL and testbench



---
 rtl/case_stream_pkg.sv | 19 +
 rtl/case_stream_ctrl_if.sv | 22 ++
 rtl/ascii_case_core.sv | 26 ++
 rtl/case_stream_ctrl.sv | 109 ++++++++++
 tb/tb_case_stream_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/case_stream_pkg.sv
// Shared constants and types for the ASCII case-conversion stream controller.
package case_stream_pkg;
  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_UPPER = 2'b01;
  localparam logic [1:0] MODE_LOWER = 2'b10;
  localparam logic [1:0] MODE_TITLE = 2'b11;

  localparam logic [7:0] CH_UA = 8'h41;
  localparam logic [7:0] CH_UZ = 8'h5A;
  localparam logic [7:0] CH_LA = 8'h61;
  localparam logic [7:0] CH_LZ = 8'h7A;

  // Case bit distinguishing 'A'..'Z' from 'a'..'z'.
  localparam logic [7:0] CASE_BIT = 8'h20;

  typedef logic [0:0] state_t;
  localparam state_t WORD_START = 1'b0;
  localparam state_t IN_WORD    = 1'b1;
endpackage

// File: rtl/case_stream_ctrl_if.sv
// Byte stream handshake: source side (s_*) in, converted output side (m_*) out.
interface case_stream_ctrl_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_cap;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_cap
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_cap
  );
endinterface

// File: rtl/ascii_case_core.sv
// Combinational ASCII case converter: flips the case bit on letters only.
module ascii_case_core
  import case_stream_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       force_upper_i,
  input  logic       force_lower_i,
  output logic [7:0] byte_o,
  output logic       is_letter_o,
  output logic       is_upper_o
);
  logic up_in, lo_in;

  assign up_in       = (byte_i >= CH_UA) && (byte_i <= CH_UZ);
  assign lo_in       = (byte_i >= CH_LA) && (byte_i <= CH_LZ);
  assign is_letter_o = up_in || lo_in;

  always_comb begin
    byte_o = byte_i;
    if (is_letter_o && force_upper_i)      byte_o = byte_i & ~CASE_BIT;
    else if (is_letter_o && force_lower_i) byte_o = byte_i | CASE_BIT;
  end

  // Non-letters never change, so the output range test alone is exact.
  assign is_upper_o = (byte_o >= CH_UA) && (byte_o <= CH_UZ);
endmodule

// File: rtl/case_stream_ctrl.sv
// Stream controller: title-case FSM, one-entry output stage, saturating letter stats.
module case_stream_ctrl
  import case_stream_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             clr_counts,
  case_stream_ctrl_if.slave sif,
  output logic [CNT_W-1:0] cap_count,
  output logic [CNT_W-1:0] letter_count
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             m_cap_q, m_cap_d;
  logic [CNT_W-1:0] cap_q, cap_d, let_q, let_d;

  logic       s_ready, acc;
  logic       force_up, force_lo;
  logic [7:0] conv;
  logic       is_letter, is_upper;

  assign s_ready = !m_valid_q || sif.m_ready;
  assign acc     = sif.s_valid && s_ready;

  assign force_up = (mode == MODE_UPPER) || ((mode == MODE_TITLE) && (state_q == WORD_START));
  assign force_lo = (mode == MODE_LOWER) || ((mode == MODE_TITLE) && (state_q == IN_WORD));

  ascii_case_core u_core (
    .byte_i        (sif.s_data),
    .force_upper_i (force_up),
    .force_lower_i (force_lo),
    .byte_o        (conv),
    .is_letter_o   (is_letter),
    .is_upper_o    (is_upper)
  );

  // Word tracking runs in every mode so switching to title mid-word keeps the word.
  always_comb begin
    state_d = state_q;
    if (acc) begin
      if (sif.s_last)     state_d = WORD_START;
      else if (is_letter) state_d = IN_WORD;
      else                state_d = WORD_START;
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_cap_d   = m_cap_q;
    if (acc) begin
      m_valid_d = 1'b1;
      m_data_d  = conv;
      m_last_d  = sif.s_last;
      m_cap_d   = is_upper;
    end else if (sif.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_comb begin
    cap_d = cap_q;
    let_d = let_q;
    if (clr_counts) begin
      cap_d = '0;
      let_d = '0;
    end else if (acc) begin
      if (is_letter && (let_q != CNT_MAX)) let_d = let_q + CNT_ONE;
      if (is_upper  && (cap_q != CNT_MAX)) cap_d = cap_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WORD_START;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_last_q  <= 1'b0;
      m_cap_q   <= 1'b0;
      cap_q     <= '0;
      let_q     <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_cap_q   <= m_cap_d;
      cap_q     <= cap_d;
      let_q     <= let_d;
    end
  end

  assign sif.s_ready   = s_ready;
  assign sif.m_valid   = m_valid_q;
  assign sif.m_data    = m_data_q;
  assign sif.m_last    = m_last_q;
  assign sif.m_cap     = m_cap_q;
  assign cap_count     = cap_q;
  assign letter_count  = let_q;
endmodule

// File: tb/tb_case_stream_ctrl.sv
// Directed bench: vector table for steady streaming plus hand sequences for stalls, saturation and reset.
module tb_case_stream_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        clr_counts;
  logic [15:0] cap_count, letter_count;
  logic [1:0]  cap2, let2;

  case_stream_ctrl_if sif();
  case_stream_ctrl_if sif2();

  assign sif2.s_valid = sif.s_valid;
  assign sif2.s_data  = sif.s_data;
  assign sif2.s_last  = sif.s_last;
  assign sif2.m_ready = sif.m_ready;

  case_stream_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clr_counts(clr_counts),
    .sif(sif), .cap_count(cap_count), .letter_count(letter_count)
  );

  case_stream_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .clr_counts(clr_counts),
    .sif(sif2), .cap_count(cap2), .letter_count(let2)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] md;
    logic [7:0] din;
    logic       lst;
    logic [7:0] dout;
    logic       cap;
    logic       olst;
    logic       chk_cnt;
    int         lc;
    int         cc;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [1:0] md, input logic [7:0] din, input logic lst,
                     input logic [7:0] dout, input logic cap, input logic olst,
                     input logic c, input int lc, input int cc);
    vec_t v;
    v.md = md; v.din = din; v.lst = lst; v.dout = dout; v.cap = cap; v.olst = olst;
    v.chk_cnt = c; v.lc = lc; v.cc = cc;
    tv.push_back(v);
  endtask

  // Present one byte; caller sits #1 after a rising edge.
  task automatic send(input logic [1:0] md, input logic [7:0] d, input logic l);
    mode = md; sif.s_data = d; sif.s_last = l; sif.s_valid = 1'b1;
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'b00; clr_counts = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = 8'h00; sif.s_last = 1'b0; sif.m_ready = 1'b1;
    #1;
    chk("rst_m_valid", sif.m_valid, 0);
    chk("rst_m_data",  sif.m_data, 8'h00);
    chk("rst_m_last",  sif.m_last, 0);
    chk("rst_m_cap",   sif.m_cap, 0);
    chk("rst_cap_cnt", cap_count, 0);
    chk("rst_let_cnt", letter_count, 0);
    chk("rst_s_ready", sif.s_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    add(2'b10, 8'h41, 0, 8'h61, 0, 0, 0, 0, 0);
    add(2'b10, 8'h4A, 0, 8'h6A, 0, 0, 0, 0, 0);
    add(2'b10, 8'h52, 0, 8'h72, 0, 0, 0, 0, 0);
    add(2'b10, 8'h5A, 0, 8'h7A, 0, 0, 1, 4, 0);
    add(2'b01, 8'h64, 0, 8'h44, 1, 0, 0, 0, 0);
    add(2'b01, 8'h76, 0, 8'h56, 1, 0, 0, 0, 0);
    add(2'b01, 8'h77, 1, 8'h57, 1, 1, 1, 7, 3);
    add(2'b11, 8'h68, 0, 8'h48, 1, 0, 0, 0, 0);
    add(2'b11, 8'h45, 0, 8'h65, 0, 0, 0, 0, 0);
    add(2'b11, 8'h4C, 0, 8'h6C, 0, 0, 0, 0, 0);
    add(2'b11, 8'h4C, 0, 8'h6C, 0, 0, 0, 0, 0);
    add(2'b11, 8'h4F, 0, 8'h6F, 0, 0, 0, 0, 0);
    add(2'b11, 8'h20, 0, 8'h20, 0, 0, 0, 0, 0);
    add(2'b11, 8'h77, 0, 8'h57, 1, 0, 0, 0, 0);
    add(2'b11, 8'h4F, 0, 8'h6F, 0, 0, 0, 0, 0);
    add(2'b11, 8'h52, 0, 8'h72, 0, 0, 0, 0, 0);
    add(2'b11, 8'h4C, 0, 8'h6C, 0, 0, 0, 0, 0);
    add(2'b11, 8'h44, 1, 8'h64, 0, 1, 1, 17, 5);
    add(2'b11, 8'h78, 0, 8'h58, 1, 0, 1, 18, 6);
    add(2'b01, 8'h40, 0, 8'h40, 0, 0, 0, 0, 0);
    add(2'b01, 8'h5B, 0, 8'h5B, 0, 0, 0, 0, 0);
    add(2'b01, 8'h60, 0, 8'h60, 0, 0, 0, 0, 0);
    add(2'b01, 8'h7B, 0, 8'h7B, 0, 0, 0, 0, 0);
    add(2'b01, 8'hE1, 0, 8'hE1, 0, 0, 1, 18, 6);
    add(2'b00, 8'h61, 0, 8'h61, 0, 0, 0, 0, 0);
    add(2'b00, 8'h62, 0, 8'h62, 0, 0, 0, 0, 0);
    add(2'b11, 8'h63, 0, 8'h63, 0, 0, 1, 21, 6);
    add(2'b11, 8'h2E, 0, 8'h2E, 0, 0, 0, 0, 0);
    add(2'b11, 8'h71, 0, 8'h51, 1, 0, 1, 22, 7);

    for (int i = 0; i < tv.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      chk({tag, "_s_ready"}, sif.s_ready, 1);
      send(tv[i].md, tv[i].din, tv[i].lst);
      chk({tag, "_m_valid"}, sif.m_valid, 1);
      chk({tag, "_m_data"},  sif.m_data, tv[i].dout);
      chk({tag, "_m_cap"},   sif.m_cap, tv[i].cap);
      chk({tag, "_m_last"},  sif.m_last, tv[i].olst);
      if (tv[i].chk_cnt) begin
        chk({tag, "_let_cnt"}, letter_count, tv[i].lc);
        chk({tag, "_cap_cnt"}, cap_count, tv[i].cc);
      end
    end

    // Drain, then stall the sink with a byte held.
    @(posedge clk); #1;
    chk("drain_m_valid", sif.m_valid, 0);
    sif.m_ready = 1'b0;
    mode = 2'b01; sif.s_data = 8'h41; sif.s_last = 1'b0; sif.s_valid = 1'b1;
    chk("bp_first_ready", sif.s_ready, 1);
    @(posedge clk); #1;
    sif.s_data = 8'h42;
    for (int c = 0; c < 3; c++) begin
      chk("bp_s_ready", sif.s_ready, 0);
      chk("bp_m_valid", sif.m_valid, 1);
      chk("bp_m_data",  sif.m_data, 8'h41);
      @(posedge clk); #1;
    end
    chk("bp_hold_data", sif.m_data, 8'h41);
    sif.m_ready = 1'b1;
    #1;
    chk("bp_release_ready", sif.s_ready, 1);
    @(posedge clk); #1;
    sif.s_valid = 1'b0;
    chk("bp_next_data",  sif.m_data, 8'h42);
    chk("bp_next_valid", sif.m_valid, 1);

    // Saturation on the 2-bit instance.
    clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    chk("clr_cap2", cap2, 0);
    chk("clr_let_cnt", letter_count, 0);
    for (int k = 0; k < 5; k++) begin
      send(2'b01, 8'h41, 0);
      chk($sformatf("sat_cap2_%0d", k), cap2, (k < 3) ? k + 1 : 3);
    end
    chk("sat_let2", let2, 3);
    chk("sat_cap16", cap_count, 5);

    // Clear wins over a simultaneous capital.
    clr_counts = 1'b1;
    send(2'b01, 8'h42, 0);
    clr_counts = 1'b0;
    chk("clrinc_m_data", sif.m_data, 8'h42);
    chk("clrinc_m_cap",  sif.m_cap, 1);
    chk("clrinc_cap",    cap_count, 0);
    chk("clrinc_let",    letter_count, 0);
    chk("clrinc_cap2",   cap2, 0);

    // Reset while a stalled byte is held; FSM left IN_WORD beforehand.
    @(posedge clk); #1;
    sif.m_ready = 1'b0;
    send(2'b00, 8'h61, 0);
    @(posedge clk); #1;
    chk("prerst_m_valid", sif.m_valid, 1);
    chk("prerst_m_data",  sif.m_data, 8'h61);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_m_valid", sif.m_valid, 0);
    chk("async_rst_m_data",  sif.m_data, 8'h00);
    chk("async_rst_s_ready", sif.s_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    sif.m_ready = 1'b1;
    @(posedge clk); #1;
    send(2'b11, 8'h71, 0);
    chk("postrst_title_data", sif.m_data, 8'h51);
    chk("postrst_title_cap",  sif.m_cap, 1);
    chk("postrst_cap_cnt",    cap_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
